// File: rtl/gk_prefix_gen16_if.sv
// Operand/result handshake bundle for the 16-bit generate/kill prefix generator.
interface gk_prefix_gen16_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] gk;
  logic [15:0] sum;
  logic        cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, gk, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, gk, sum, cout
  );
endinterface

// File: rtl/gk_prefix_gen16.sv
// Sequential 16-bit generate/kill prefix generator: encodes operands into GK codes,
// resolves them with four Kogge-Stone steps and presents gk, sum and cout.
module gk_prefix_gen16 (
  input  logic              clk,
  input  logic              rst_n,
  gk_prefix_gen16_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] code_q, code_d;
  logic [15:0] p_q, p_d;
  logic        cin_q, cin_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] gk_q, gk_d;
  logic [15:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic [31:0] step_code;

  // Bit 0 has no lower neighbour, so cin resolves its propagate case directly.
  function automatic logic [31:0] encode(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      if (a[i] && b[i])        c[2*i +: 2] = 2'b11;
      else if (!a[i] && !b[i]) c[2*i +: 2] = 2'b00;
      else                     c[2*i +: 2] = 2'b10;
    end
    if (c[1:0] == 2'b10) c[1:0] = {cin, cin};
    return c;
  endfunction

  // Any code with unequal bits (10, or the never-produced 01) counts as propagate.
  function automatic logic [31:0] combine(input logic [31:0] c, input logic [1:0] s);
    logic [31:0] r;
    int          d;
    r = c;
    d = 1 << s;
    for (int i = 0; i < 16; i++) begin
      if (i >= d && (c[2*i+1] ^ c[2*i])) r[2*i +: 2] = c[2*(i-d) +: 2];
    end
    return r;
  endfunction

  function automatic logic [15:0] form_sum(input logic [15:0] p, input logic cin,
                                           input logic [31:0] g);
    logic [15:0] s;
    s[0] = p[0] ^ cin;
    for (int i = 1; i < 16; i++) s[i] = p[i] ^ g[2*i-1];
    return s;
  endfunction

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    code_d      = code_q;
    p_d         = p_q;
    cin_d       = cin_q;
    cnt_d       = cnt_q;
    gk_d        = gk_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    step_code   = combine(code_q, cnt_q);
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          code_d     = encode(bus.a, bus.b, bus.cin);
          p_d        = bus.a ^ bus.b;
          cin_d      = bus.cin;
          cnt_d      = 2'd0;
          in_ready_d = 1'b0;
          state_d    = STEP;
        end
      end
      STEP: begin
        code_d = step_code;
        cnt_d  = cnt_q + 2'd1;
        // Outputs are loaded from the final step's result on the same edge.
        if (cnt_q == 2'd3) begin
          gk_d        = step_code;
          sum_d       = form_sum(p_q, cin_q, step_code);
          cout_d      = step_code[31];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      code_q      <= '0;
      p_q         <= '0;
      cin_q       <= 1'b0;
      cnt_q       <= 2'd0;
      gk_q        <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      code_q      <= code_d;
      p_q         <= p_d;
      cin_q       <= cin_d;
      cnt_q       <= cnt_d;
      gk_q        <= gk_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.gk        = gk_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_gk_prefix_gen16.sv
// Scoreboard bench for gk_prefix_gen16: stimulus pushes expected results, a monitor pops them.
module tb_gk_prefix_gen16;

  typedef struct packed {
    logic [31:0] gk;
    logic [15:0] sum;
    logic        cout;
  } exp_t;

  logic clk;
  logic rst_n;
  gk_prefix_gen16_if bus ();

  gk_prefix_gen16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: hold off

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference: carry out of bit i is bit i+1 of the sum of the low i+1 bits.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t        e;
    logic [16:0] t;
    logic [16:0] mask;
    t      = {1'b0, a} + {1'b0, b} + {16'd0, c};
    e.sum  = t[15:0];
    e.cout = t[16];
    e.gk   = '0;
    for (int i = 0; i < 16; i++) begin
      mask = (17'd1 << (i + 1)) - 17'd1;
      t    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'd0, c};
      e.gk[2*i]   = t[i+1];
      e.gk[2*i+1] = t[i+1];
    end
    return e;
  endfunction

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                      input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = ta;
    bus.b        = tb;
    bus.cin      = tc;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin : monitor
    logic r;
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = 1'b0;
      endcase
      bus.out_ready = r;
      if (bus.out_valid && r) begin
        got = {bus.gk, bus.sum, bus.cout};
        if (sb.size() == 0) begin
          chk("unexpected_result", {15'd0, got}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("result", {15'd0, got}, {15'd0, e});
        end
      end
    end
  end

  initial begin : stim
    exp_t held;
    int   n;
    exp_t lit;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    #3;
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_outputs", {15'd0, bus.gk, bus.sum, bus.cout}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", {63'd0, bus.in_ready}, 64'd1);

    // Directed vectors with literal expectations.
    lit = '{gk: 32'h0000FFFF, sum: 16'h0100, cout: 1'b0};
    send(16'h00FF, 16'h0001, 1'b0, lit);
    lit = '{gk: 32'hFFFFFFFF, sum: 16'h0000, cout: 1'b1};
    send(16'hFFFF, 16'h0000, 1'b1, lit);
    lit = '{gk: 32'h00000000, sum: 16'hFFFF, cout: 1'b0};
    send(16'hFFFF, 16'h0000, 1'b0, lit);

    // Backpressure: hold out_ready low for 10 cycles while in_valid toggles.
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    rdy_mode = 2;
    send(16'hA5C3, 16'h3C5A, 1'b1, model(16'hA5C3, 16'h3C5A, 1'b1));
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_out_valid_rise", {63'd0, bus.out_valid}, 64'd1);
    held = {bus.gk, bus.sum, bus.cout};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      chk("bp_hold", {13'd0, bus.out_valid, bus.in_ready, bus.gk, bus.sum, bus.cout},
          {13'd0, 1'b1, 1'b0, held});
    end
    bus.in_valid = 1'b0;
    #1;
    rdy_mode = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("bp_release", {62'd0, bus.out_valid, bus.in_ready}, {62'd0, 1'b0, 1'b1});

    // Reset during step s=2.
    send(16'h7777, 16'h1111, 1'b0, model(16'h7777, 16'h1111, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", {62'd0, bus.out_valid, bus.in_ready}, 64'd0);
    chk("midreset_data", {15'd0, bus.gk, bus.sum, bus.cout}, 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    lit      = model(16'h1234, 16'h0FED, 1'b1);
    lit.sum  = 16'h2222;
    lit.cout = 1'b0;
    send(16'h1234, 16'h0FED, 1'b1, lit);

    // Random vectors with stalls on both sides.
    rdy_mode = 1;
    for (int v = 0; v < 2000; v++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, model(ra, rb, rc));
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gk_prefix_gen16.md
# gk_prefix_gen16

Sequential 16-bit carry-status (generate/kill) prefix generator for the arithmetic datapath. It accepts two 16-bit operands plus carry-in over a valid/ready handshake and encodes each bit position as a 2-bit GK code. It then resolves the codes with four iterative Kogge-Stone combine steps and presents a fully resolved 32-bit GK vector, which the 16-bit GK-to-carry converter collapses to carries. The block also outputs sum and carry-out, so downstream logic and the bench can check results directly.

## Interface
- No parameters; width fixed at 16 bits / 32-bit GK vector.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands (registered).
- a  input  16  operand A.
- b  input  16  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts result.
- gk  output  32  resolved code, bit i in gk[2i+1:2i]; 2'b11 = carry out of bit i is 1, 2'b00 = carry out is 0.
- sum  output  16  a + b + cin, low 16 bits.
- cout  output  1  carry out of bit 15; equals gk[31].

## Operation
- Code encoding for each bit i:
  - 2'b11 generate: a[i] & b[i].
  - 2'b00 kill: ~a[i] & ~b[i].
  - 2'b10 propagate: otherwise.
  - 2'b01 is never produced. The block treats 01 as propagate if it ever appears.
- Carry-in fold: at encode, bit 0 propagate becomes 11 if cin = 1, else 00.
- Combine rule for step s (distance d = 1<<s, s = 0..3):
  - For i ≥ d: if code[i] is propagate, code[i] takes the value of code[i-d]; otherwise code[i] is unchanged.
  - For i < d: code[i] is unchanged.
  - All positions update simultaneously from the previous register values.
- After step 3, no propagate codes remain.
- Result formation:
  - p = a^b is registered at accept.
  - sum[0] = p[0]^cin.
  - sum[i] = p[i]^gk[2i-1] for i ≥ 1.
  - cout = gk[31].
- FSM states:
  - IDLE: in_ready = 1. On in_valid & in_ready: register the encoded codes, p and cin; clear the step counter; go to STEP.
  - STEP: apply step s = counter, then increment. After the s = 3 edge, go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- Outputs gk, sum and cout update only when entering DONE and are held stable throughout DONE.
- Outputs keep their last values in IDLE and STEP. Consumers qualify them with out_valid.

## Timing
- Reset (asynchronous, immediate) values:
  - state = IDLE.
  - in_ready = 0, out_valid = 0.
  - gk = 0, sum = 0, cout = 0.
  - Step counter = 0.
- in_ready rises on the first rising clk edge after rst_n deasserts.
- Accept edge = T0. STEP edges are T1–T4. out_valid is high from T4 onward, so latency is 4 cycles from acceptance.
- out_valid stays high with all outputs stable while out_ready = 0. There is no timeout.
- The edge where out_valid & out_ready are both high drops out_valid and raises in_ready. The next accept can occur on the following edge.
- Minimum initiation interval is 6 cycles.
- in_ready is 0 throughout STEP and DONE. in_valid and operand changes in those states are ignored.
- in_valid must hold stable until accepted; the block samples operands only on the accept edge.
- Reset asserted in any state (including mid-STEP or DONE with out_ready high) aborts the operation. No partial result is ever presented.

## Test plan
- a=0x00FF, b=0x0001, cin=0 → 4 cycles after accept: gk=0x0000FFFF, sum=0x0100, cout=0.
- a=0xFFFF, b=0x0000, cin=1 (full propagate chain) → gk=0xFFFFFFFF, sum=0x0000, cout=1.
- a=0xFFFF, b=0x0000, cin=0 → gk=0x00000000, sum=0xFFFF, cout=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises.
  - Required: gk, sum, cout and out_valid stay stable; in_ready stays 0; in_valid toggling is ignored.
  - Then raise out_ready: the next cycle shows out_valid=0 and in_ready=1.
- Reset mid-operation: drop rst_n during step s=2.
  - Required: out_valid=0, in_ready=0, gk=0, sum=0 immediately.
  - After release: in_ready=1 after one edge; a new op a=0x1234, b=0x0FED, cin=1 gives sum=0x2222, cout=0.
- 2000 random operand/cin vectors with random in_valid/out_ready stalls.
  - Required: every result matches a+b+cin.
  - gk[2i+1] == gk[2i] == carry out of bit i.
  - No result is dropped or duplicated, and results arrive in order.
